// File: rtl/fb_scanner_pkg.sv
// fb_scanner_pkg: framebuffer geometry and scanner FSM states shared
// by the scanner, its refresh timer and the bench.
package fb_scanner_pkg;

    localparam logic [11:0] FB_BASE_DEFAULT = 12'h100;
    localparam int          FB_BYTES        = 256;
    localparam int          FB_ROW_BYTES    = 8;
    localparam int          FB_ROWS         = 32;
    localparam int          FB_WIDTH        = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GPU,
        ST_READ,
        ST_OUT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fb_scanner_if.sv
// fb_scanner interfaces: memory read port and the pixel-byte stream
// towards the display driver.
interface fb_mem_if;
    logic        mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte;
    logic        mem_read_ack;

    modport master (
        output mem_read, mem_read_idx,
        input  mem_read_byte, mem_read_ack
    );
    modport slave (
        input  mem_read, mem_read_idx,
        output mem_read_byte, mem_read_ack
    );
endinterface

interface fb_out_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic [4:0] out_row;
    logic [2:0] out_col;
    logic       out_last;

    modport master (
        output out_valid, out_byte, out_row, out_col, out_last,
        input  out_ready
    );
    modport slave (
        input  out_valid, out_byte, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/fb_scanner_refresh_timer.sv
// fb_scanner_refresh_timer: free-running period counter, one-cycle tick
// on the last count; PERIOD of 0 leaves it permanently silent.
module fb_scanner_refresh_timer #(
    parameter int unsigned PERIOD = 0
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = (PERIOD == 0) ? '0 : W'(PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (PERIOD == 0 || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = (PERIOD != 0) && (cnt_q == LAST);

endmodule

// File: rtl/fb_scanner.sv
// fb_scanner: streams the 64x32 framebuffer from main memory to the
// display driver one byte at a time, tagged with row and byte column.
module fb_scanner
    import fb_scanner_pkg::*;
#(
    parameter logic [11:0] FB_BASE        = FB_BASE_DEFAULT,
    parameter int unsigned REFRESH_CYCLES = 0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     refresh,
    input  logic     gpu_busy,
    fb_mem_if.master mem,
    fb_out_if.master out,
    output logic     frame_busy,
    output logic     frame_done
);

    localparam logic [7:0] LAST_IDX = 8'(FB_BYTES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pending_q, pending_d;
    logic [7:0] byte_q, byte_d;
    logic [4:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic       last_q, last_d;
    logic       tick;

    fb_scanner_refresh_timer #(
        .PERIOD (REFRESH_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        row_d     = row_q;
        col_d     = col_q;
        last_d    = last_q;
        pending_d = pending_q | refresh | tick;
        unique case (state_q)
            ST_IDLE: begin
                if (pending_q) state_d = ST_WAIT_GPU;
            end
            ST_WAIT_GPU: begin
                // a request landing on the start cycle still counts
                if (!gpu_busy) begin
                    state_d   = ST_READ;
                    pending_d = refresh | tick;
                end
            end
            ST_READ: begin
                if (mem.mem_read_ack) begin
                    byte_d  = mem.mem_read_byte;
                    row_d   = cnt_q[7:3];
                    col_d   = cnt_q[2:0];
                    last_d  = (cnt_q == LAST_IDX);
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out.out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            byte_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            byte_q    <= byte_d;
            row_q     <= row_d;
            col_q     <= col_d;
            last_q    <= last_d;
        end
    end

    assign mem.mem_read     = (state_q == ST_READ);
    assign mem.mem_read_idx = FB_BASE + {4'b0000, cnt_q};
    assign out.out_valid    = (state_q == ST_OUT);
    assign out.out_byte     = byte_q;
    assign out.out_row      = row_q;
    assign out.out_col      = col_q;
    assign out.out_last     = last_q;
    assign frame_busy       = (state_q == ST_READ) || (state_q == ST_OUT);
    assign frame_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_fb_scanner.sv
// tb_fb_scanner: randomized memory/backpressure stimulus, stream checked
// against a byte-index model of the framebuffer scan order.
module tb_fb_scanner;
    import fb_scanner_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic refresh = 1'b0;
    logic gpu_busy = 1'b0;
    logic frame_busy, frame_done;
    logic a_busy, a_done;

    fb_mem_if m_if ();
    fb_out_if o_if ();
    fb_mem_if am_if ();
    fb_out_if ao_if ();

    fb_scanner u_dut (
        .clk        (clk),
        .reset      (reset),
        .refresh    (refresh),
        .gpu_busy   (gpu_busy),
        .mem        (m_if),
        .out        (o_if),
        .frame_busy (frame_busy),
        .frame_done (frame_done)
    );

    fb_scanner #(.REFRESH_CYCLES(2000)) u_auto (
        .clk        (clk),
        .reset      (reset),
        .refresh    (1'b0),
        .gpu_busy   (1'b0),
        .mem        (am_if),
        .out        (ao_if),
        .frame_busy (a_busy),
        .frame_done (a_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  b;
        logic [4:0]  r;
        logic [2:0]  c;
        logic        l;
    } xfer_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] cyc = '0;
    logic [7:0]  mem [256];
    bit          lat_en = 1'b0;
    bit          spur_en = 1'b0;
    int          wait_n = 0;
    xfer_t       xq[$];
    logic [31:0] dq[$];
    logic [31:0] sq[$];
    logic [31:0] asq[$];
    int          adn = 0;
    logic        mr_prev = 1'b0;
    logic        amr_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // memory with optional random latency and stray acks while idle
    always @(negedge clk) begin
        if (m_if.mem_read) begin
            if (wait_n > 0) begin
                wait_n--;
                m_if.mem_read_ack = 1'b0;
                m_if.mem_read_byte = 8'($urandom);
            end else begin
                m_if.mem_read_ack = 1'b1;
                m_if.mem_read_byte = mem[8'(m_if.mem_read_idx - 12'h100)];
            end
        end else begin
            m_if.mem_read_ack = spur_en ? 1'($urandom) : 1'b0;
            m_if.mem_read_byte = 8'($urandom);
            wait_n = lat_en ? int'($urandom_range(0, 2)) : 0;
        end
    end

    always @(negedge clk) begin
        am_if.mem_read_ack = am_if.mem_read;
        am_if.mem_read_byte = mem[8'(am_if.mem_read_idx - 12'h100)];
    end

    assign ao_if.out_ready = 1'b1;

    always @(negedge clk) begin
        if (!reset) begin
            if (o_if.out_valid && o_if.out_ready)
                xq.push_back(xfer_t'{cyc, o_if.out_byte, o_if.out_row,
                                     o_if.out_col, o_if.out_last});
            if (frame_done) dq.push_back(cyc);
            if (m_if.mem_read && !mr_prev && m_if.mem_read_idx == 12'h100)
                sq.push_back(cyc);
            if (am_if.mem_read && !amr_prev && a_busy &&
                am_if.mem_read_idx == 12'h100)
                asq.push_back(cyc);
            if (a_done) adn++;
        end
        mr_prev = m_if.mem_read;
        amr_prev = am_if.mem_read;
    end

    function automatic logic [16:0] exp_x(input int i);
        return {mem[i], i[7:3], i[2:0], i == 255};
    endfunction

    function automatic logic [16:0] act_x(input xfer_t x);
        return {x.b, x.r, x.c, x.l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
    endtask

    task automatic clear_q();
        xq.delete();
        dq.delete();
        sq.delete();
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (dq.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (dq.size() >= n);
    endtask

    task automatic test_reset();
        o_if.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({m_if.mem_read, o_if.out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_rd_valid: got %b, want 00",
                     {m_if.mem_read, o_if.out_valid});
        end
        n_checks++;
        if ({frame_busy, frame_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_busy_done: got %b, want 00",
                     {frame_busy, frame_done});
        end
        n_checks++;
        if (m_if.mem_read_idx !== 12'h100) begin
            n_fail++;
            $display("FAIL reset_idx: got %h, want 100", m_if.mem_read_idx);
        end
        n_checks++;
        if ({o_if.out_byte, o_if.out_row, o_if.out_col, o_if.out_last} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_out_regs: got %h, want 0",
                     {o_if.out_byte, o_if.out_row, o_if.out_col, o_if.out_last});
        end
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_order();
        bit ok;
        int bad;
        logic [31:0] rc;
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'hFF;
        mem[8] = 8'hC3;
        mem[255] = 8'h81;
        lat_en = 1'b0;
        spur_en = 1'b0;
        o_if.out_ready = 1'b1;
        tick();
        clear_q();
        rc = cyc;
        pulse_refresh();
        wait_frames(1, 3000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL order_timeout: got %0d frames, want 1", dq.size());
        end
        n_checks++;
        if (xq.size() != 256) begin
            n_fail++;
            $display("FAIL order_count: got %0d transfers, want 256", xq.size());
        end
        n_checks++;
        if (sq.size() < 1 || sq[0] != rc + 3) begin
            n_fail++;
            $display("FAIL order_start_latency: got %0d, want %0d",
                     sq.size() > 0 ? sq[0] : 0, rc + 3);
        end
        if (xq.size() == 256) begin
            n_checks++;
            if (act_x(xq[0]) !== {8'hFF, 5'd0, 3'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL order_xfer0: got %h, want %h", act_x(xq[0]),
                         {8'hFF, 5'd0, 3'd0, 1'b0});
            end
            n_checks++;
            if (act_x(xq[8]) !== {8'hC3, 5'd1, 3'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL order_xfer8: got %h, want %h", act_x(xq[8]),
                         {8'hC3, 5'd1, 3'd0, 1'b0});
            end
            n_checks++;
            if (act_x(xq[255]) !== {8'h81, 5'd31, 3'd7, 1'b1}) begin
                n_fail++;
                $display("FAIL order_xfer255: got %h, want %h", act_x(xq[255]),
                         {8'h81, 5'd31, 3'd7, 1'b1});
            end
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (act_x(xq[i]) !== exp_x(i)) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL order_stream: %0d bytes differ, want 0", bad);
            end
            n_checks++;
            if (xq[1].cyc - xq[0].cyc != 2) begin
                n_fail++;
                $display("FAIL order_byte_spacing: got %0d, want 2",
                         xq[1].cyc - xq[0].cyc);
            end
            n_checks++;
            if (dq.size() != 1 || dq[0] != xq[255].cyc + 1) begin
                n_fail++;
                $display("FAIL order_done_timing: got %0d, want %0d",
                         dq.size() > 0 ? dq[0] : 0, xq[255].cyc + 1);
            end
        end
        n_checks++;
        if ({frame_busy, frame_done, m_if.mem_read} !== 3'b000) begin
            n_fail++;
            $display("FAIL order_idle_after: got %b, want 000",
                     {frame_busy, frame_done, m_if.mem_read});
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        int k;
        logic [15:0] snap;
        foreach (mem[i]) mem[i] = 8'($urandom);
        lat_en = 1'b1;
        spur_en = 1'b1;
        o_if.out_ready = 1'b1;
        tick();
        clear_q();
        pulse_refresh();
        k = 0;
        while (!(o_if.out_valid && o_if.out_row == 5'd0 && o_if.out_col == 3'd3)
               && k < 3000) begin
            tick();
            k++;
        end
        o_if.out_ready = 1'b0;
        snap = {o_if.out_byte, o_if.out_row, o_if.out_col};
        n_checks++;
        if (snap !== {mem[3], 5'd0, 3'd3}) begin
            n_fail++;
            $display("FAIL bp_held_byte: got %h, want %h", snap, {mem[3], 5'd0, 3'd3});
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if ({o_if.out_valid, m_if.mem_read, o_if.out_byte, o_if.out_row,
                 o_if.out_col} !== {2'b10, snap}) begin
                n_fail++;
                $display("FAIL bp_stall_%0d: got %h, want %h", c,
                         {o_if.out_valid, m_if.mem_read, o_if.out_byte,
                          o_if.out_row, o_if.out_col}, {2'b10, snap});
            end
        end
        o_if.out_ready = 1'b1;
        wait_frames(1, 4000, ok);
        n_checks++;
        if (!ok || xq.size() != 256) begin
            n_fail++;
            $display("FAIL bp_count: got %0d transfers, want 256", xq.size());
        end
        if (xq.size() == 256) begin
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (act_x(xq[i]) !== exp_x(i)) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL bp_stream: %0d bytes differ, want 0", bad);
            end
        end
    endtask

    task automatic test_gpu_gating();
        bit ok;
        int bad;
        int k;
        logic [31:0] g;
        foreach (mem[i]) mem[i] = 8'($urandom);
        o_if.out_ready = 1'b1;
        gpu_busy = 1'b1;
        tick();
        clear_q();
        pulse_refresh();
        bad = 0;
        repeat (50) begin
            tick();
            if (m_if.mem_read || frame_busy) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL gpu_hold: %0d cycles with read/busy, want 0", bad);
        end
        gpu_busy = 1'b0;
        g = cyc;
        repeat (4) tick();
        n_checks++;
        if (sq.size() != 1 || sq[0] > g + 2) begin
            n_fail++;
            $display("FAIL gpu_release: got start %0d, want <= %0d",
                     sq.size() > 0 ? sq[0] : 0, g + 2);
        end
        k = 0;
        while (xq.size() < 20 && k < 2000) begin
            tick();
            k++;
        end
        gpu_busy = 1'b1;
        wait_frames(1, 4000, ok);
        gpu_busy = 1'b0;
        n_checks++;
        if (!ok || xq.size() != 256) begin
            n_fail++;
            $display("FAIL gpu_midframe_count: got %0d, want 256", xq.size());
        end
        if (xq.size() == 256) begin
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (act_x(xq[i]) !== exp_x(i)) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL gpu_stream: %0d bytes differ, want 0", bad);
            end
        end
    endtask

    task automatic test_coalesce();
        bit ok;
        int bad;
        int k;
        foreach (mem[i]) mem[i] = 8'($urandom);
        lat_en = 1'b1;
        spur_en = 1'b1;
        o_if.out_ready = 1'b1;
        tick();
        clear_q();
        pulse_refresh();
        k = 0;
        while (xq.size() < 10 && k < 2000) begin
            tick();
            k++;
        end
        for (int p = 0; p < 3; p++) begin
            repeat ($urandom_range(5, 60)) tick();
            pulse_refresh();
        end
        wait_frames(1, 4000, ok);
        k = 0;
        while (!frame_done && k < 4000) begin
            tick();
            k++;
        end
        pulse_refresh();
        wait_frames(3, 5000, ok);
        bad = 0;
        repeat (1000) begin
            tick();
            if (m_if.mem_read) bad++;
        end
        n_checks++;
        if (dq.size() != 3 || sq.size() != 3) begin
            n_fail++;
            $display("FAIL coalesce_frames: got %0d done/%0d starts, want 3/3",
                     dq.size(), sq.size());
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL coalesce_idle: %0d read cycles, want 0", bad);
        end
        n_checks++;
        if (xq.size() != 768) begin
            n_fail++;
            $display("FAIL coalesce_count: got %0d, want 768", xq.size());
        end
        if (xq.size() == 768) begin
            bad = 0;
            for (int i = 0; i < 768; i++)
                if (act_x(xq[i]) !== exp_x(i % 256)) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL coalesce_stream: %0d bytes differ, want 0", bad);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int bad;
        int k;
        int d0;
        int x0;
        foreach (mem[i]) mem[i] = 8'($urandom);
        lat_en = 1'b1;
        spur_en = 1'b1;
        o_if.out_ready = 1'b1;
        tick();
        clear_q();
        pulse_refresh();
        k = 0;
        while (xq.size() < 100 && k < 3000) begin
            tick();
            k++;
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({m_if.mem_read, o_if.out_valid, frame_busy, frame_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: got %b, want 0000",
                     {m_if.mem_read, o_if.out_valid, frame_busy, frame_done});
        end
        n_checks++;
        if ({o_if.out_byte, o_if.out_row, o_if.out_col, o_if.out_last} !== 17'd0) begin
            n_fail++;
            $display("FAIL rst_mid_regs: got %h, want 0",
                     {o_if.out_byte, o_if.out_row, o_if.out_col, o_if.out_last});
        end
        d0 = dq.size();
        repeat (2) tick();
        reset = 1'b0;
        x0 = xq.size();
        bad = 0;
        repeat (30) begin
            tick();
            if (o_if.out_valid || m_if.mem_read) bad++;
        end
        n_checks++;
        if (bad != 0 || dq.size() != d0 || xq.size() != x0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: got %0d busy cycles %0d dones, want 0 0",
                     bad, dq.size() - d0);
        end
        clear_q();
        pulse_refresh();
        wait_frames(1, 4000, ok);
        n_checks++;
        if (!ok || xq.size() != 256 || sq.size() != 1) begin
            n_fail++;
            $display("FAIL rst_restart: got %0d transfers %0d starts, want 256 1",
                     xq.size(), sq.size());
        end
        if (xq.size() == 256) begin
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (act_x(xq[i]) !== exp_x(i)) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rst_restart_stream: %0d bytes differ, want 0", bad);
            end
        end
    endtask

    task automatic test_auto_refresh();
        int k;
        o_if.out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) tick();
        asq.delete();
        adn = 0;
        clear_q();
        reset = 1'b0;
        k = 0;
        while (asq.size() < 4 && k < 9000) begin
            tick();
            k++;
        end
        n_checks++;
        if (asq.size() < 4) begin
            n_fail++;
            $display("FAIL auto_starts: got %0d, want 4", asq.size());
        end
        for (int i = 1; i < 4; i++) begin
            if (asq.size() > i) begin
                n_checks++;
                if (asq[i] - asq[i-1] != 2000) begin
                    n_fail++;
                    $display("FAIL auto_period_%0d: got %0d, want 2000", i,
                             asq[i] - asq[i-1]);
                end
            end
        end
        n_checks++;
        if (adn < 3) begin
            n_fail++;
            $display("FAIL auto_done: got %0d frames, want >= 3", adn);
        end
        n_checks++;
        if (sq.size() != 0) begin
            n_fail++;
            $display("FAIL manual_no_auto: got %0d starts, want 0", sq.size());
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_backpressure();
        test_gpu_gating();
        test_coalesce();
        test_reset_midframe();
        test_auto_refresh();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
